// File: rtl/pipe_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder.
// Optional signed-overflow output is enabled with PIPE_ADDER_OVF_EN.
package pipe_adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 8;

    function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
        return (chunk == 0) ? 0 : width / chunk;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width != 0) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// io_out_Ovf exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_A;
    logic [WIDTH-1:0] io_in_B;
    logic             io_in_Cin;
    logic             io_in_sub;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_Sum;
    logic             io_out_Cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             io_out_Ovf;
`endif

    modport master (
        output io_in_valid, io_in_A, io_in_B, io_in_Cin, io_in_sub, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_Sum,
`ifdef PIPE_ADDER_OVF_EN
        input  io_out_Ovf,
`endif
        input  io_out_Cout
    );

    modport slave (
        input  io_in_valid, io_in_A, io_in_B, io_in_Cin, io_in_sub, io_out_ready,
        output io_in_ready, io_out_valid, io_out_Sum,
`ifdef PIPE_ADDER_OVF_EN
        output io_out_Ovf,
`endif
        output io_out_Cout
    );

endinterface

// File: rtl/pipe_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module adder_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    always_comb begin : p_ripple
        logic c;
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit ripple segment per stage,
// bubble-collapsing valid/ready flow control. PIPE_ADDER_OVF_EN adds io_out_Ovf.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input logic        clock,
    input logic        reset,
    pipe_adder_if.slave io
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);
    localparam int unsigned LAST   = STAGES - 1;

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $error("pipe_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    // Operands travel whole; sum chunks at and below the stage index are final.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } stage_t;

    stage_t            st [STAGES];
    stage_t            up [STAGES];
    stage_t            nx [STAGES];
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  chunk_sum;
    logic [STAGES-1:0] chunk_cout;

    always_comb begin : p_upstream
        up[0] = '{valid: io.io_in_valid,
                  carry: io.io_in_sub | io.io_in_Cin,
                  a:     io.io_in_A,
                  b:     io.io_in_sub ? ~io.io_in_B : io.io_in_B,
                  sum:   '0};
        for (int unsigned k = 1; k < STAGES; k++) begin
            up[k] = st[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (up[k].a[k*CHUNK +: CHUNK]),
            .b    (up[k].b[k*CHUNK +: CHUNK]),
            .cin  (up[k].carry),
            .sum  (chunk_sum[k*CHUNK +: CHUNK]),
            .cout (chunk_cout[k])
        );
    end

    always_comb begin : p_next
        for (int unsigned k = 0; k < STAGES; k++) begin
            nx[k]                       = up[k];
            nx[k].carry                 = chunk_cout[k];
            nx[k].sum[k*CHUNK +: CHUNK] = chunk_sum[k*CHUNK +: CHUNK];
        end
    end

    // Unrolled form of rdy[k] = !v[k] || rdy[k+1]: any empty slot at or after k.
    always_comb begin : p_ready
        for (int unsigned k = 0; k < STAGES; k++) begin
            rdy[k] = io.io_out_ready;
            for (int unsigned j = k; j < STAGES; j++) begin
                if (!st[j].valid) rdy[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (reset) begin
                st[k] <= '0;
            end else if (rdy[k]) begin
                if (up[k].valid) st[k] <= nx[k];
                else             st[k].valid <= 1'b0;
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;
    logic msb_carry_in;

    assign msb_carry_in = up[LAST].a[WIDTH-1] ^ up[LAST].b[WIDTH-1] ^ chunk_sum[WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (rdy[LAST] && up[LAST].valid) begin
            ovf_q <= msb_carry_in ^ chunk_cout[LAST];
        end
    end

    assign io.io_out_Ovf = ovf_q;
`endif

    assign io.io_in_ready  = rdy[0];
    assign io.io_out_valid = st[LAST].valid;
    assign io.io_out_Sum   = st[LAST].sum;
    assign io.io_out_Cout  = st[LAST].carry;

endmodule
